// File: rtl/two_four_decoder_pipe_pkg.sv
// ---------------------------------------------------------------------------
// two_four_decoder_pipe_pkg
// Shared definitions for the 2:4 decoder pipeline.
//   CODE_W     - width of the binary line index (2)
//   LINE_CNT   - number of decoded output lines (4)
//   ZERO_WORD  - decoded word when no line is active
//   bufState_t - occupancy of the 2-entry output skid buffer
//   decodeLine - binary index (+ zero flag) to one-hot line word
// ---------------------------------------------------------------------------
package two_four_decoder_pipe_pkg;

    localparam int CODE_W   = 2;
    localparam int LINE_CNT = 4;

    localparam logic [LINE_CNT-1:0] ZERO_WORD = '0;

    // Buffer occupancy: EMPTY holds no word, BUSY holds one word in the
    // main register, FULL holds a second word in the skid register too.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } bufState_t;

    // The index is only looked at when isZero is low, so an unknown code
    // alongside a set zero flag still decodes cleanly to the all-zero word.
    function automatic logic [LINE_CNT-1:0] decodeLine(
        input logic [CODE_W-1:0] code,
        input logic              isZero
    );
        logic [LINE_CNT-1:0] word;
        word = ZERO_WORD;
        if (!isZero) begin
            word[code] = 1'b1;
        end
        return word;
    endfunction

endpackage

// File: rtl/two_four_decoder_pipe_skid_buffer.sv
// ---------------------------------------------------------------------------
// skid_buffer
// Two-entry valid/ready output stage: a main register that drives the
// downstream side and a skid register that catches the one word that can
// arrive after the main register stalls.
//   Clk       - clock, all state updates on the rising edge
//   Rst       - synchronous active-high reset, discards both entries
//   in_valid  - upstream word on in_data is valid
//   in_ready  - registered, high while the skid register is empty
//   in_data   - upstream word
//   out_valid - main register holds a word
//   out_ready - downstream takes the main register word this cycle
//   out_data  - main register contents
// ---------------------------------------------------------------------------
module skid_buffer
    import two_four_decoder_pipe_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    bufState_t         state;
    bufState_t         stateNext;
    logic [DATA_W-1:0] mainReg;
    logic [DATA_W-1:0] skidReg;
    logic              inReadyReg;
    logic              accept;
    logic              drain;
    logic              loadMainFromIn;
    logic              loadMainFromSkid;
    logic              loadSkid;

    assign accept    = in_valid && inReadyReg;
    assign drain     = (state != EMPTY) && out_ready;
    assign in_ready  = inReadyReg;
    assign out_valid = (state != EMPTY);
    assign out_data  = mainReg;

    // Next-state and register-load decisions. A new word normally goes
    // straight into the main register; it only lands in the skid register
    // when the main register is occupied and not draining. When the main
    // register drains while FULL, the skid word moves up so ordering is
    // preserved. in_ready is low in FULL, so no accept can occur there.
    always_comb begin
        stateNext        = state;
        loadMainFromIn   = 1'b0;
        loadMainFromSkid = 1'b0;
        loadSkid         = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    stateNext      = BUSY;
                    loadMainFromIn = 1'b1;
                end
            end
            BUSY: begin
                if (accept && drain) begin
                    loadMainFromIn = 1'b1;
                end else if (accept) begin
                    stateNext = FULL;
                    loadSkid  = 1'b1;
                end else if (drain) begin
                    stateNext = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    stateNext        = BUSY;
                    loadMainFromSkid = 1'b1;
                end
            end
            default: begin
                stateNext = EMPTY;
            end
        endcase
    end

    // State, data and ready registers. in_ready is registered from the
    // next state so it falls the cycle after the skid register fills and
    // rises the cycle after it empties; it is held low throughout reset
    // and comes up on the first edge without reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= EMPTY;
            mainReg    <= '0;
            skidReg    <= '0;
            inReadyReg <= 1'b0;
        end else begin
            state      <= stateNext;
            inReadyReg <= (stateNext != FULL);
            if (loadMainFromIn) begin
                mainReg <= in_data;
            end else if (loadMainFromSkid) begin
                mainReg <= skidReg;
            end
            if (loadSkid) begin
                skidReg <= in_data;
            end
        end
    end

endmodule

// File: rtl/two_four_decoder_pipe.sv
// ---------------------------------------------------------------------------
// two_four_decoder_pipe
// Pipelined 2:4 decoder with a valid/ready handshake on both sides.
//   CNT_W     - width of the saturating accepted-word counter
//   Clk       - clock, all state updates on the rising edge
//   Rst       - synchronous active-high reset
//   in_valid  - upstream word (Y, zero) is valid
//   in_ready  - block can accept a word this cycle
//   Y         - binary index of the active line
//   zero      - no line active, Y ignored
//   out_valid - W holds a valid decoded word
//   out_ready - downstream accepts W this cycle
//   W         - registered one-hot word, or all zeros when zero was set
//   cnt       - saturating count of words accepted since reset
// ---------------------------------------------------------------------------
module two_four_decoder_pipe
    import two_four_decoder_pipe_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CODE_W-1:0]   Y,
    input  logic                zero,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LINE_CNT-1:0] W,
    output logic [CNT_W-1:0]    cnt
);

    logic [LINE_CNT-1:0] decodedWord;
    logic                accept;

    assign accept = in_valid && in_ready;

    // Decode sits ahead of the buffer so the word stored in the main
    // register is already one-hot; this gives the single cycle of latency.
    always_comb begin
        decodedWord = decodeLine(Y, zero);
    end

    skid_buffer #(
        .DATA_W (LINE_CNT)
    ) outBuffer (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (decodedWord),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (W)
    );

    // Accepted-word counter. Every handshake counts, including all-zero
    // words, and the count sticks at its maximum instead of wrapping.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt <= '0;
        end else if (accept && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/two_four_decoder_pipe.md
TWO_FOUR_DECODER_PIPE -- requirements
Module: two_four_decoder_pipe

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 8, width of the saturating accepted-word counter.
REQ-002 Clk  input  1  the block's only clock; all state SHALL update on its rising edge.
REQ-003 Rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  the upstream word (Y, zero) is valid.
REQ-005 in_ready  output  1  the block can accept a word this cycle.
REQ-006 Y  input  2  binary code: index of the active line.
REQ-007 zero  input  1  no line is active; when high, Y is ignored.
REQ-008 out_valid  output  1  W holds a valid decoded word.
REQ-009 out_ready  input  1  downstream accepts W this cycle.
REQ-010 W  output  4  registered one-hot decoded word, or 4'b0000 when zero was set.
REQ-011 cnt  output  CNT_W  saturating count of words accepted since reset.

Function
REQ-012 The block SHALL accept an input word on every cycle in which in_valid and in_ready are both high.
REQ-013 The decode SHALL map zero=1 to 4'b0000, and map zero=0 with Y=00/01/10/11 to 4'b0001/0010/0100/1000.
REQ-014 The decode SHALL be the exact inverse of the team's 4:2 encoder for every one-hot W and for W=0000.
REQ-015 The latency SHALL be 1 cycle: a word accepted at edge N SHALL appear on W, with out_valid high, after edge N when the output register is empty or draining.
REQ-016 The output stage SHALL be a 2-entry skid buffer holding a main register and a skid register.
REQ-017 The block SHALL sustain 1 word/cycle while out_ready is high.
REQ-018 in_ready SHALL be registered and SHALL equal "skid register empty".
REQ-019 When out_valid=1 and out_ready=0, W and out_valid SHALL hold stable until the word is accepted.
REQ-020 If a word is accepted while the main register is stalled, it SHALL go to the skid register and in_ready SHALL drop on the next cycle.
REQ-021 When the main register drains with the skid register full, the skid word SHALL move to the main register and in_ready SHALL rise on the next cycle.
REQ-022 The buffer SHALL never drop, duplicate or reorder words.
REQ-023 The buffer SHALL have 3 states, EMPTY (0 words), BUSY (1 word) and FULL (2 words), with these transitions:
- EMPTY->BUSY on accept.
- BUSY->EMPTY on drain without accept.
- BUSY->FULL on accept without drain.
- FULL->BUSY on drain.
- All other cases SHALL stay in the current state.
REQ-024 A simultaneous accept and drain in BUSY SHALL stay in BUSY, with the new word loaded into the main register.
REQ-025 cnt SHALL increment by 1 on each accept and saturate at 2^CNT_W-1 without wrapping.
REQ-026 zero=1 words SHALL be counted in cnt.
REQ-027 When zero=1, the value of Y SHALL have no effect on W, including when Y is X.

Reset
REQ-028 While Rst=1 at a clock edge, the block SHALL set out_valid=0, W=4'b0000, cnt=0, state=EMPTY, and in_ready=0.
REQ-029 in_ready SHALL become 1 on the first edge with Rst=0.
REQ-030 Rst asserted mid-operation SHALL discard all buffered words, and no stale word SHALL appear after reset.
REQ-031 Input handshakes SHALL be ignored while Rst=1.

Structure
REQ-032 A shared header SHALL define the code width (2), the line count (4), the all-zero word constant, and the buffer state encodings (EMPTY/BUSY/FULL).
REQ-033 The buffer SHALL be one sub-module, skid_buffer, parameterized by data width (4 here).
REQ-034 The decode SHALL be combinational logic ahead of skid_buffer in two_four_decoder_pipe, and the counter SHALL be in the top module.

Verification
REQ-035 The bench SHALL check reset: Rst=1 for 2 cycles with in_valid=1 -> out_valid=0, W=0000, cnt=0, in_ready=0; in_ready=1 one cycle after Rst falls.
REQ-036 The bench SHALL check streaming: out_ready=1, back-to-back Y=0,1,2,3 then zero=1 (Y=X) -> W=0001,0010,0100,1000,0000 on consecutive cycles from 1 cycle after the first accept; cnt=5.
REQ-037 The bench SHALL check backpressure: out_ready=0 with 3 words offered (Y=2,3,1) -> W=0100 held stable, 2 accepted, in_ready low; release out_ready -> W=0100,1000 then third word 0010, with no loss.
REQ-038 The bench SHALL check simultaneous events: BUSY with accept and drain on the same edge for 10 cycles -> state stays BUSY and each W matches its Y from one cycle earlier.
REQ-039 The bench SHALL check reset mid-operation: FULL, then Rst for 1 cycle -> out_valid=0, W=0000, cnt=0, and the buffered words never appear.
REQ-040 The bench SHALL check saturation: CNT_W=3 with 10 accepts -> cnt=7 held with no wrap; the encoder-decoder loopback over all 5 legal W SHALL return identity.
